inliers_scan_master: RTL and testbench

- Avalon-MM master that drives the memory-mapped inlier-check register block, i.e. the initiator side of that register interface.
- On `start` it does three things:
  - writes the line model and threshold once;
  - streams N points from point memory into the x/y registers;
  - reads back each inlier flag and accumulates the inlier count.
- Sits between the RANSAC control logic and the system interconnect, so the NIOS no longer loops per point.

---
 rtl/inliers_scan_master_if.sv | 13 +
 rtl/inliers_scan_master.sv | 101 ++++++++++
 tb/tb_inliers_scan_master.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/inliers_scan_master_if.sv
// inliers_scan_master_if: Avalon-MM bus bundle between the scan master and the interconnect
interface inliers_scan_master_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] address;
  logic read;
  logic write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic waitrequest;
  modport master(output address, read, write, writedata, input readdata, waitrequest);
  modport slave(input address, read, write, writedata, output readdata, waitrequest);
endinterface

// File: rtl/inliers_scan_master.sv
// inliers_scan_master: Avalon-MM master that programs the inlier-check block, streams N points through it and counts inliers
module inliers_scan_master #(
  parameter int ADDR_W = 32,
  parameter logic [31:0] INLIER_BASE = 32'h0000_1000,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic [31:0] scale_factor,
  input  logic [31:0] line_a,
  input  logic [31:0] line_b,
  input  logic [31:0] threshold,
  input  logic [ADDR_W-1:0] point_base,
  input  logic [CNT_W-1:0] num_points,
  output logic busy,
  output logic done,
  output logic [CNT_W-1:0] inlier_count,
  inliers_scan_master_if.master avm
);
  typedef enum logic [3:0] {IDLE, W_SCALE, W_A, W_B, W_THR, R_X, R_Y, W_X, W_Y, R_RES, FINISH} state_t;
  localparam logic [ADDR_W-1:0] base = ADDR_W'(INLIER_BASE);
  state_t state, nxt;
  logic [31:0] scale_q, a_q, b_q, thr_q, x_q, y_q, cmd_data;
  logic [ADDR_W-1:0] pb_q, pt_addr, cmd_addr;
  logic [CNT_W-1:0] n_q, idx;
  logic active, last, cmd_wr;
  assign active = avm.read | avm.write;
  assign pt_addr = pb_q + (ADDR_W'(idx) << 3);
  always_comb begin
    last = idx == n_q - CNT_W'(1);
    cmd_wr = state inside {W_SCALE, W_A, W_B, W_THR, W_X, W_Y};
    cmd_data = state == W_SCALE ? scale_q : state == W_A ? a_q : state == W_B ? b_q :
               state == W_THR ? thr_q : state == W_X ? x_q : state == W_Y ? y_q : '0;
    cmd_addr = state == R_X ? pt_addr : state == R_Y ? pt_addr + ADDR_W'(4) :
               base + ADDR_W'(state == W_A ? 4 : state == W_B ? 8 : state == W_THR ? 20 :
                               state == W_X ? 12 : state == W_Y ? 16 : 0);
    nxt = state == W_SCALE ? W_A : state == W_A ? W_B : state == W_B ? W_THR :
          state == W_THR ? (n_q == '0 ? FINISH : R_X) : state == R_X ? R_Y : state == R_Y ? W_X :
          state == W_X ? W_Y : state == W_Y ? R_RES : state == R_RES ? (last ? FINISH : R_X) : IDLE;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      inlier_count <= '0;
      idx <= '0;
      avm.read <= 1'b0;
      avm.write <= 1'b0;
      avm.address <= '0;
      avm.writedata <= '0;
      scale_q <= '0;
      a_q <= '0;
      b_q <= '0;
      thr_q <= '0;
      x_q <= '0;
      y_q <= '0;
      pb_q <= '0;
      n_q <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE:
          if (start) begin
            scale_q <= scale_factor;
            a_q <= line_a;
            b_q <= line_b;
            thr_q <= threshold;
            pb_q <= point_base;
            n_q <= num_points;
            inlier_count <= '0;
            idx <= '0;
            busy <= 1'b1;
            state <= W_SCALE;
          end
        FINISH: state <= IDLE;
        default:
          if (!active) begin
            avm.address <= cmd_addr;
            avm.write <= cmd_wr;
            avm.read <= !cmd_wr;
            avm.writedata <= cmd_data;
          end else if (!avm.waitrequest) begin
            avm.read <= 1'b0;
            avm.write <= 1'b0;
            state <= nxt;
            if (state == R_X) x_q <= avm.readdata;
            if (state == R_Y) y_q <= avm.readdata;
            if (state == R_RES) begin
              inlier_count <= inlier_count + CNT_W'(avm.readdata[0]);
              idx <= last ? idx : idx + CNT_W'(1);
            end
            if (nxt == FINISH) begin
              busy <= 1'b0;
              done <= 1'b1;
            end
          end
      endcase
    end
endmodule

// File: tb/tb_inliers_scan_master.sv
// tb_inliers_scan_master: directed and random scans against a bus slave with point memory and an inlier-check register model
module tb_inliers_scan_master;
  localparam logic [31:0] BASE = 32'h0000_1000;
  typedef struct packed {logic wr; logic [31:0] addr; logic [31:0] data;} xfer_t;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [31:0] scale_factor = '0, line_a = '0, line_b = '0, threshold = '0, point_base = '0;
  logic [15:0] num_points = '0;
  logic busy, done;
  logic [15:0] inlier_count;
  int checks = 0, errors = 0;
  xfer_t got[$], exp_q[$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] regs [6];
  logic [31:0] px[$], py[$];
  logic [31:0] p_s, p_a, p_b, p_t, p_pb;
  bit of[$], ovr_q[$];
  bit ovr = 1'b0, stall_rnd = 1'b0, chk_stable = 1'b0;
  int stall_fix = 0, stall_res = 0, wcnt = 0, cur_stall = 0, done_cnt = 0, exp_cnt = 0;
  logic [65:0] snap;
  logic active, is_res;
  inliers_scan_master_if #(.ADDR_W(32)) avm();
  inliers_scan_master dut (
    .clk(clk), .reset(reset), .start(start), .scale_factor(scale_factor), .line_a(line_a),
    .line_b(line_b), .threshold(threshold), .point_base(point_base), .num_points(num_points),
    .busy(busy), .done(done), .inlier_count(inlier_count), .avm(avm)
  );
  always #5 clk = ~clk;
  function automatic bit inl(input logic [31:0] s, a, b, t, x, y);
    longint d;
    d = longint'($signed(s)) * longint'($signed(y)) - longint'($signed(a)) * longint'($signed(x)) - longint'($signed(b));
    if (d < 0) d = -d;
    return d <= longint'($signed(t));
  endfunction
  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  assign active = avm.read | avm.write;
  assign is_res = avm.read && (avm.address - BASE) < 32'd24;
  assign avm.waitrequest = active && wcnt < (is_res ? stall_res : cur_stall);
  always @(posedge clk) begin
    chk_stable <= active && avm.waitrequest && !reset;
    snap <= {avm.read, avm.write, avm.address, avm.writedata};
    if (!active) begin
      wcnt <= 0;
      cur_stall <= stall_rnd ? int'($urandom_range(0, 2)) : stall_fix;
    end else if (avm.waitrequest) wcnt <= wcnt + 1;
    else begin
      got.push_back({avm.write, avm.address, avm.write ? avm.writedata : avm.readdata});
      if (avm.write && (avm.address - BASE) < 32'd24) regs[(avm.address - BASE) >> 2] <= avm.writedata;
      if (is_res && ovr && ovr_q.size() > 0) void'(ovr_q.pop_front());
      wcnt <= 0;
    end
  end
  always @(negedge clk) begin
    if (!$isunknown(avm.address)) begin
      if ((avm.address - BASE) < 32'd24)
        avm.readdata = {31'd0, ovr ? (ovr_q.size() > 0 && ovr_q[0]) : inl(regs[0], regs[1], regs[2], regs[5], regs[3], regs[4])};
      else
        avm.readdata = mem.exists(avm.address) ? mem[avm.address] : 32'hDEAD_BEEF;
    end
    if (!reset) chk("rd_wr_exclusive", avm.read & avm.write, 0);
    if (chk_stable) chk("cmd_stable_in_stall", {avm.read, avm.write, avm.address, avm.writedata}, snap);
    if (done === 1'b1) begin
      done_cnt++;
      chk("busy_low_with_done", busy, 0);
    end
  end
  task automatic build_exp();
    logic [31:0] pa;
    bit f;
    exp_q.delete();
    exp_cnt = 0;
    exp_q.push_back({1'b1, BASE, p_s});
    exp_q.push_back({1'b1, BASE + 32'd4, p_a});
    exp_q.push_back({1'b1, BASE + 32'd8, p_b});
    exp_q.push_back({1'b1, BASE + 32'd20, p_t});
    for (int i = 0; i < px.size(); i++) begin
      pa = p_pb + 32'(8 * i);
      f = ovr ? of[i] : inl(p_s, p_a, p_b, p_t, px[i], py[i]);
      exp_q.push_back({1'b0, pa, px[i]});
      exp_q.push_back({1'b0, pa + 32'd4, py[i]});
      exp_q.push_back({1'b1, BASE + 32'd12, px[i]});
      exp_q.push_back({1'b1, BASE + 32'd16, py[i]});
      exp_q.push_back({1'b0, BASE, {31'd0, f}});
      exp_cnt += int'(f);
    end
  endtask
  task automatic drive_and_start();
    for (int i = 0; i < px.size(); i++) begin
      mem[p_pb + 32'(8 * i)] = px[i];
      mem[p_pb + 32'(8 * i + 4)] = py[i];
    end
    ovr_q = of;
    got.delete();
    done_cnt = 0;
    scale_factor = p_s;
    line_a = p_a;
    line_b = p_b;
    threshold = p_t;
    point_base = p_pb;
    num_points = 16'(px.size());
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask
  task automatic scan(input string tag, input bit perturb);
    int c = 0, bad = 0, first = -1;
    build_exp();
    drive_and_start();
    chk({tag, "_busy_after_start"}, busy, 1);
    while (done !== 1'b1 && c < 5000) begin
      @(negedge clk);
      c++;
      if (perturb && c == 5) begin
        start = 1'b1;
        num_points = 16'd7;
        scale_factor = $urandom;
        line_a = $urandom;
        line_b = $urandom;
        threshold = $urandom;
        point_base = 32'h2000_0000;
      end
      if (perturb && c == 6) start = 1'b0;
    end
    chk({tag, "_done_seen"}, done, 1);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk({tag, "_start_in_finish_ignored"}, busy, 0);
    repeat (3) @(negedge clk);
    chk({tag, "_busy_idle"}, busy, 0);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_inlier_count"}, inlier_count, exp_cnt);
    chk({tag, "_xfer_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      if (got[i] !== exp_q[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    chk({tag, "_xfer_first_bad_index"}, first, -1);
  endtask
  task automatic set_pts(input int n, input bit rnd);
    px.delete();
    py.delete();
    of.delete();
    for (int i = 0; i < n; i++) begin
      px.push_back(rnd ? $urandom_range(0, 7) : 32'(2 * i + 1));
      py.push_back(rnd ? $urandom_range(0, 20) : 32'(2 * i + 2));
    end
  endtask
  initial begin
    int c;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_count", inlier_count, 0);
    chk("reset_read", avm.read, 0);
    chk("reset_write", avm.write, 0);
    chk("reset_address", avm.address, 0);
    chk("reset_writedata", avm.writedata, 0);
    reset = 1'b0;
    @(negedge clk);
    // zero-latency slave, forced flags 1,0,1
    set_pts(3, 0);
    of = '{1, 0, 1};
    ovr = 1'b1;
    {p_s, p_a, p_b, p_t, p_pb} = {32'd7, 32'd8, 32'd9, 32'd10, 32'h0001_0000};
    scan("n3", 0);
    chk("n3_xfers_19", got.size(), 19);
    chk("n3_count_2", inlier_count, 2);
    // no points: parameter writes only
    set_pts(0, 0);
    of.delete();
    scan("n0", 0);
    chk("n0_xfers_4", got.size(), 4);
    // three-cycle stall on every transfer, all flags set
    set_pts(2, 0);
    of = '{1, 1};
    stall_fix = 3;
    p_pb = 32'h0002_0040;
    scan("stall3", 0);
    chk("stall3_count_2", inlier_count, 2);
    stall_fix = 0;
    // real line-model flags
    ovr = 1'b0;
    px = '{0, 1, 2, 3};
    py = '{1, 3, 9, 7};
    {p_s, p_a, p_b, p_t} = {32'd1, 32'd2, 32'd1, 32'd1};
    scan("model", 0);
    chk("model_count_3", inlier_count, 3);
    // start re-pulsed and inputs changed mid-scan
    scan("perturbed", 1);
    chk("perturbed_count_3", inlier_count, 3);
    // reset while R_RES of point 1 is stalled
    build_exp();
    drive_and_start();
    c = 0;
    while (inlier_count !== 16'd1 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    chk("rst_first_inlier_seen", inlier_count, 1);
    stall_res = 1000;
    c = 0;
    while (!(avm.read && avm.address == BASE) && c < 2000) begin
      @(negedge clk);
      c++;
    end
    chk("rst_rres_reached", avm.read && avm.address == BASE, 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    done_cnt = 0;
    @(negedge clk) reset = 1'b0;
    chk("rst_read_dropped", avm.read, 0);
    chk("rst_write_low", avm.write, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", inlier_count, 0);
    stall_res = 0;
    repeat (5) @(negedge clk);
    chk("rst_no_done", done_cnt, 0);
    chk("rst_still_idle", busy, 0);
    scan("after_reset", 0);
    // random scans with random stalls, one with address wrap
    stall_rnd = 1'b1;
    for (int r = 0; r < 5; r++) begin
      set_pts($urandom_range(1, 6), 1);
      p_s = $urandom_range(1, 3);
      p_a = $urandom_range(0, 3);
      p_b = $urandom_range(0, 3);
      p_t = $urandom_range(0, 4);
      p_pb = r == 0 ? 32'hFFFF_FFF8 : 32'h0003_0000 + 32'(8 * $urandom_range(0, 255));
      scan($sformatf("rand%0d", r), 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
